control_unit: RTL and testbench

//  Instruction-sequencing FSM for the basic adding-machine CPU; it drives the program counter's control pins.
//  - Generates clr_pc / inc_pc / ld_pc for the PC.
//  - Generates MAR, IR, memory and accumulator strobes.
//  - Runs fetch -> decode -> execute. Instruction word = {opcode[1:0], addr[5:0]}.
//  - Sits between IR/memory and the PC/AC datapath. jump_addr to the PC comes from IR[5:0], not from this block.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/control_unit.sv | 124 ++++++++++++
 tb/tb_control_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the adding-machine CPU: field widths, opcodes and
// control-unit state encodings.
package cpu_pkg;

    localparam int OPC_W  = 2;
    localparam int ADDR_W = 6;
    localparam int ST_W   = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 2'b00;
    localparam logic [OPC_W-1:0] OP_STA = 2'b01;
    localparam logic [OPC_W-1:0] OP_JMP = 2'b10;
    localparam logic [OPC_W-1:0] OP_HLT = 2'b11;

    localparam logic [ST_W-1:0] S_INIT = 4'd0;
    localparam logic [ST_W-1:0] S_IDLE = 4'd1;
    localparam logic [ST_W-1:0] S_F1   = 4'd2;
    localparam logic [ST_W-1:0] S_F2   = 4'd3;
    localparam logic [ST_W-1:0] S_DEC  = 4'd4;
    localparam logic [ST_W-1:0] S_A1   = 4'd5;
    localparam logic [ST_W-1:0] S_A2   = 4'd6;
    localparam logic [ST_W-1:0] S_S1   = 4'd7;
    localparam logic [ST_W-1:0] S_S2   = 4'd8;
    localparam logic [ST_W-1:0] S_JMP  = 4'd9;
    localparam logic [ST_W-1:0] S_HALT = 4'd10;

endpackage

// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the adding-machine CPU. Walks
// fetch -> decode -> execute and drives the PC, MAR, IR, memory and AC
// strobes. Strobes are a pure decode of the state register, with the IR,
// PC-increment and AC loads additionally gated by mem_ready.
module control_unit #(
    parameter int OPC_W = 2,
    parameter int ST_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic            mem_ready,
    output logic            clr_pc,
    output logic            inc_pc,
    output logic            ld_pc,
    output logic            ld_mar,
    output logic            mar_sel,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            ld_ir,
    output logic            clr_ac,
    output logic            ld_ac,
    output logic            halted,
    output logic [ST_W-1:0] state_dbg
);

    import cpu_pkg::OP_ADD;
    import cpu_pkg::OP_STA;
    import cpu_pkg::OP_JMP;
    import cpu_pkg::OP_HLT;
    import cpu_pkg::S_INIT;
    import cpu_pkg::S_IDLE;
    import cpu_pkg::S_F1;
    import cpu_pkg::S_F2;
    import cpu_pkg::S_DEC;
    import cpu_pkg::S_A1;
    import cpu_pkg::S_A2;
    import cpu_pkg::S_S1;
    import cpu_pkg::S_S2;
    import cpu_pkg::S_JMP;
    import cpu_pkg::S_HALT;

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;

    assign state_dbg = state;

    // State register; reset forces INIT without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; memory states hold until mem_ready, HALT only exits via rst.
    always_comb begin
        state_nxt = S_INIT;
        case (state)
            S_INIT: state_nxt = S_IDLE;
            S_IDLE: state_nxt = start ? S_F1 : S_IDLE;
            S_F1:   state_nxt = S_F2;
            S_F2:   state_nxt = mem_ready ? S_DEC : S_F2;
            S_DEC: begin
                case (ir_opcode)
                    OP_ADD:  state_nxt = S_A1;
                    OP_STA:  state_nxt = S_S1;
                    OP_JMP:  state_nxt = S_JMP;
                    OP_HLT:  state_nxt = S_HALT;
                    default: state_nxt = S_INIT;
                endcase
            end
            S_A1:   state_nxt = S_A2;
            S_A2:   state_nxt = mem_ready ? S_F1 : S_A2;
            S_S1:   state_nxt = S_S2;
            S_S2:   state_nxt = mem_ready ? S_F1 : S_S2;
            S_JMP:  state_nxt = S_F1;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_INIT;
        endcase
    end

    // Output decode; unused encodings leave every strobe low.
    always_comb begin
        clr_pc  = 1'b0;
        inc_pc  = 1'b0;
        ld_pc   = 1'b0;
        ld_mar  = 1'b0;
        mar_sel = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ld_ir   = 1'b0;
        clr_ac  = 1'b0;
        ld_ac   = 1'b0;
        halted  = 1'b0;
        case (state)
            S_INIT: begin
                clr_pc = 1'b1;
                clr_ac = 1'b1;
            end
            S_F1: ld_mar = 1'b1;
            S_F2: begin
                mem_rd = 1'b1;
                ld_ir  = mem_ready;
                inc_pc = mem_ready;
            end
            S_A1, S_S1: begin
                ld_mar  = 1'b1;
                mar_sel = 1'b1;
            end
            S_A2: begin
                mem_rd = 1'b1;
                ld_ac  = mem_ready;
            end
            S_S2:   mem_wr = 1'b1;
            S_JMP:  ld_pc  = 1'b1;
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-cycle vector table walking
// reset, IDLE, ADD, STA with wait states, JMP and HLT, plus hand-written
// reset sequences and continuous mutual-exclusion checks.
module tb_control_unit;

    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] ir_opcode = 2'b00;
    logic       mem_ready = 1'b0;
    logic       clr_pc, inc_pc, ld_pc, ld_mar, mar_sel, mem_rd, mem_wr;
    logic       ld_ir, clr_ac, ld_ac, halted;
    logic [3:0] state_dbg;

    // Strobe vector order: clr_pc inc_pc ld_pc ld_mar mar_sel mem_rd mem_wr ld_ir clr_ac ld_ac halted
    localparam logic [10:0] O_NONE   = 11'b000_0000_0000;
    localparam logic [10:0] O_CLRPC  = 11'b100_0000_0000;
    localparam logic [10:0] O_INCPC  = 11'b010_0000_0000;
    localparam logic [10:0] O_LDPC   = 11'b001_0000_0000;
    localparam logic [10:0] O_LDMAR  = 11'b000_1000_0000;
    localparam logic [10:0] O_MARSEL = 11'b000_0100_0000;
    localparam logic [10:0] O_MEMRD  = 11'b000_0010_0000;
    localparam logic [10:0] O_MEMWR  = 11'b000_0001_0000;
    localparam logic [10:0] O_LDIR   = 11'b000_0000_1000;
    localparam logic [10:0] O_CLRAC  = 11'b000_0000_0100;
    localparam logic [10:0] O_LDAC   = 11'b000_0000_0010;
    localparam logic [10:0] O_HALT   = 11'b000_0000_0001;

    localparam logic [10:0] E_INIT  = O_CLRPC | O_CLRAC;
    localparam logic [10:0] E_FETCH = O_MEMRD | O_LDIR | O_INCPC;
    localparam logic [10:0] E_OPMAR = O_LDMAR | O_MARSEL;

    control_unit #(.OPC_W(2), .ST_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ir_opcode(ir_opcode),
        .mem_ready(mem_ready), .clr_pc(clr_pc), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_mar(ld_mar), .mar_sel(mar_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ld_ir(ld_ir), .clr_ac(clr_ac), .ld_ac(ld_ac), .halted(halted),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [10:0] outs;
    assign outs = {clr_pc, inc_pc, ld_pc, ld_mar, mar_sel, mem_rd, mem_wr,
                   ld_ir, clr_ac, ld_ac, halted};

    typedef struct {
        logic        start;
        logic [1:0]  op;
        logic        rdy;
        logic [10:0] exp;
        logic [3:0]  st;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic s, input logic [1:0] o, input logic r,
                       input logic [10:0] e, input logic [3:0] st);
        vec_t v;
        v.start = s; v.op = o; v.rdy = r; v.exp = e; v.st = st;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [10:0] e, input logic [3:0] st);
        checks++;
        if (outs !== e || state_dbg !== st) begin
            errors++;
            $display("FAIL %s strobes=%b expected=%b state=%0d expected=%0d",
                     nm, outs, e, state_dbg, st);
        end
    endtask

    // Mutual-exclusion invariants, sampled mid-cycle once inputs have settled.
    always @(negedge clk) begin
        #2;
        checks++;
        assert ((32'(clr_pc) + 32'(inc_pc) + 32'(ld_pc)) <= 1) else begin
            errors++;
            $display("FAIL pc_onehot clr=%b inc=%b ld=%b required at most one", clr_pc, inc_pc, ld_pc);
        end
        checks++;
        assert (!(mem_rd && mem_wr)) else begin
            errors++;
            $display("FAIL rd_wr_excl mem_rd=%b mem_wr=%b required not both", mem_rd, mem_wr);
        end
        checks++;
        assert (!(ld_ir || ld_ac) || mem_ready) else begin
            errors++;
            $display("FAIL gated_load ld_ir=%b ld_ac=%b mem_ready=%b required ready", ld_ir, ld_ac, mem_ready);
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset released; INIT, then 10 idle cycles, then start.
        add(0, 2'b00, 0, E_INIT, S_INIT);
        for (int i = 0; i < 10; i++) add(0, 2'b00, i[0], O_NONE, S_IDLE);
        add(1, 2'b00, 0, O_NONE, S_IDLE);
        // ADD 5 (0x05) with zero-wait memory; mem_ready high in F1 is ignored.
        add(0, 2'b00, 1, O_LDMAR, S_F1);
        add(0, 2'b00, 1, E_FETCH, S_F2);
        add(0, 2'b00, 1, O_NONE, S_DEC);
        add(0, 2'b00, 1, E_OPMAR, S_A1);
        add(0, 2'b00, 1, O_MEMRD | O_LDAC, S_A2);
        // STA 10 (0x4A), three wait cycles in S2; start pulses are ignored.
        add(1, 2'b01, 1, O_LDMAR, S_F1);
        add(0, 2'b01, 1, E_FETCH, S_F2);
        add(0, 2'b01, 1, O_NONE, S_DEC);
        add(0, 2'b01, 1, E_OPMAR, S_S1);
        add(0, 2'b01, 0, O_MEMWR, S_S2);
        add(1, 2'b01, 0, O_MEMWR, S_S2);
        add(0, 2'b01, 0, O_MEMWR, S_S2);
        add(0, 2'b01, 1, O_MEMWR, S_S2);
        // JMP 3 (0x83), with one fetch wait cycle that must not load IR.
        add(0, 2'b10, 0, O_LDMAR, S_F1);
        add(0, 2'b10, 0, O_MEMRD, S_F2);
        add(0, 2'b10, 1, E_FETCH, S_F2);
        add(0, 2'b10, 0, O_NONE, S_DEC);
        add(0, 2'b10, 1, O_LDPC, S_JMP);
        // HLT (0xC0): halted from the cycle after DEC, inputs ignored.
        add(0, 2'b11, 1, O_LDMAR, S_F1);
        add(0, 2'b11, 1, E_FETCH, S_F2);
        add(0, 2'b11, 1, O_NONE, S_DEC);
        for (int i = 0; i < 20; i++) add(i[0], 2'b00, ~i[0], O_HALT, S_HALT);

        // Asynchronous reset holds INIT decode while asserted.
        @(negedge clk);
        #1 chk("reset_hold", E_INIT, S_INIT);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            start     = vq[i].start;
            ir_opcode = vq[i].op;
            mem_ready = vq[i].rdy;
            #1 chk($sformatf("vec%0d", i), vq[i].exp, vq[i].st);
            @(negedge clk);
        end

        // Reset out of HALT takes effect without a clock edge.
        start = 1'b0; mem_ready = 1'b0;
        rst = 1'b1;
        #1 chk("halt_rst_async", E_INIT, S_INIT);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("halt_rst_init", E_INIT, S_INIT);
        @(negedge clk);
        #1 chk("halt_rst_idle", O_NONE, S_IDLE);

        // Walk into S2 and abandon the write with a mid-cycle reset.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 chk("s2seq_f1", O_LDMAR, S_F1);
        @(negedge clk); mem_ready = 1'b1;
        #1 chk("s2seq_f2", E_FETCH, S_F2);
        @(negedge clk); ir_opcode = 2'b01;
        @(negedge clk);
        #1 chk("s2seq_s1", E_OPMAR, S_S1);
        @(negedge clk); mem_ready = 1'b0;
        #1 chk("s2seq_s2", O_MEMWR, S_S2);
        #2 rst = 1'b1;
        #1 chk("s2_rst_async", E_INIT, S_INIT);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("s2_rst_idle", O_NONE, S_IDLE);

        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
